// File: rtl/bias_add_stage.sv
// Per-lane bias add with 18-bit saturation over a 2-stage valid/ready pipeline.
// Optional ReLU after saturation when BIAS_RELU_EN is defined.
module bias_add_stage #(
    parameter int unsigned N_adder_tree = 16,
    parameter int unsigned DATA_W       = 18,
    parameter int unsigned PIXELS       = 49
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_adder_tree*DATA_W-1:0] bias,
    input  logic [N_adder_tree*DATA_W-1:0] in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [N_adder_tree*DATA_W-1:0] out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           sat_flag,
    input  logic                           sat_clr
);

    localparam int unsigned CntW = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(PIXELS - 1);

    logic                                  s1_valid_q;
    logic [N_adder_tree-1:0][DATA_W:0]     s1_sum_q, s1_sum_d;
    logic                                  s2_valid_q;
    logic [N_adder_tree-1:0][DATA_W-1:0]   s2_data_q, s2_data_d;
    logic [CntW-1:0]                       pix_cnt_q, pix_cnt_d;
    logic                                  sat_flag_q, sat_flag_d;

    logic                                  s2_load, s1_load, out_fire, sat_event;
    logic [N_adder_tree-1:0]               hi_clip, lo_clip;

    assign s2_load  = ~s2_valid_q | out_ready;
    assign s1_load  = ~s1_valid_q | s2_load;
    assign in_ready = s1_load;
    assign out_fire = s2_valid_q & out_ready;

    // Sign-extend both operands by one bit so the sum cannot wrap.
    always_comb begin
        s1_sum_d = s1_sum_q;
        for (int unsigned i = 0; i < N_adder_tree; i++) begin
            s1_sum_d[i] = {in_data[i*DATA_W + DATA_W - 1], in_data[i*DATA_W +: DATA_W]}
                        + {bias[i*DATA_W + DATA_W - 1], bias[i*DATA_W +: DATA_W]};
        end
    end

    // Clipping shows up as the two top bits of the widened sum disagreeing.
    always_comb begin
        s2_data_d = s2_data_q;
        hi_clip   = '0;
        lo_clip   = '0;
        for (int unsigned i = 0; i < N_adder_tree; i++) begin
            hi_clip[i]   = ~s1_sum_q[i][DATA_W] & s1_sum_q[i][DATA_W-1];
            lo_clip[i]   = s1_sum_q[i][DATA_W] & ~s1_sum_q[i][DATA_W-1];
            s2_data_d[i] = s1_sum_q[i][DATA_W-1:0];
            if (hi_clip[i]) begin
                s2_data_d[i] = {1'b0, {(DATA_W-1){1'b1}}};
            end else if (lo_clip[i]) begin
                s2_data_d[i] = {1'b1, {(DATA_W-1){1'b0}}};
            end
`ifdef BIAS_RELU_EN
            if (s2_data_d[i][DATA_W-1]) begin
                s2_data_d[i] = '0;
            end
`else
`endif
        end
    end

    assign sat_event = s2_load & s1_valid_q & (|(hi_clip | lo_clip));

    always_comb begin
        sat_flag_d = sat_flag_q;
        if (sat_event) begin
            sat_flag_d = 1'b1;
        end else if (sat_clr) begin
            sat_flag_d = 1'b0;
        end
    end

    always_comb begin
        pix_cnt_d = pix_cnt_q;
        if (out_fire) begin
            pix_cnt_d = (pix_cnt_q == LastCnt) ? '0 : pix_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            pix_cnt_q  <= '0;
            sat_flag_q <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid_q <= in_valid;
                s1_sum_q   <= s1_sum_d;
            end
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= s2_data_d;
                end
            end
            pix_cnt_q  <= pix_cnt_d;
            sat_flag_q <= sat_flag_d;
        end
    end

    assign out_data  = s2_data_q;
    assign out_valid = s2_valid_q;
    assign out_last  = s2_valid_q & (pix_cnt_q == LastCnt);
    assign sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_bias_add_stage.sv
// Directed bench for bias_add_stage: add, saturation, ReLU, backpressure, framing.
module tb_bias_add_stage;

    localparam int N  = 16;
    localparam int W  = 18;
    localparam int BW = N * W;
`ifdef BIAS_RELU_EN
    localparam bit Relu = 1'b1;
`else
    localparam bit Relu = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [BW-1:0] bias, in_data, out_data;
    logic          in_valid, in_ready, out_valid, out_ready, out_last, sat_flag, sat_clr;

    int n_vec = 0;
    int n_bad = 0;

    bias_add_stage #(
        .N_adder_tree(N),
        .DATA_W      (W),
        .PIXELS      (49)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bias     (bias),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .sat_flag (sat_flag),
        .sat_clr  (sat_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1, "timeout");
    end

    function automatic logic [BW-1:0] bus2(input int a, input int b);
        logic [BW-1:0] v;
        v = '0;
        v[W-1:0]   = W'(a);
        v[2*W-1:W] = W'(b);
        return v;
    endfunction

    function automatic int relu(input int x);
        return (Relu && x < 0) ? 0 : x;
    endfunction

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One isolated beat; returns at the cycle its result sits on out_data.
    task automatic send1(input int a, input int b, input bit clr);
        @(negedge clk);
        in_data   = bus2(a, b);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        sat_clr  = clr;
        @(negedge clk);
        sat_clr = 1'b0;
        #1;
    endtask

    task automatic stream(input int n_send, input int n_recv, input int last_a, input int last_b);
        int sent = 0;
        int rcv  = 0;
        int cyc  = 0;
        out_ready = 1'b1;
        while (rcv < n_recv && cyc < n_recv + 20) begin
            @(negedge clk);
            in_valid = (sent < n_send);
            in_data  = bus2(1000 + sent, 0);
            #1;
            if (out_valid) begin
                rcv++;
                chk("frame_last", BW'(out_last), BW'(rcv == last_a || rcv == last_b));
                chk("frame_data", BW'(out_data[W-1:0]), BW'(675 + rcv));
            end
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        chk("frame_count", BW'(rcv), BW'(n_recv));
    endtask

    initial begin
        int sent, rcv, cyc;
        bit saw_block, have_prev;
        logic [BW-1:0] prev;

        in_valid  = 1'b0;
        out_ready = 1'b0;
        sat_clr   = 1'b0;
        in_data   = '0;
        bias      = bus2(-324, 12124);

        // Reset held while inputs wiggle
        repeat (4) begin
            @(negedge clk);
            in_valid  = ~in_valid;
            out_ready = ~out_ready;
            in_data   = bus2(131000, -131072);
            sat_clr   = ~sat_clr;
        end
        #1;
        chk("rst_out_valid", BW'(out_valid), '0);
        chk("rst_sat_flag", BW'(sat_flag), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_last", BW'(out_last), '0);
        @(negedge clk);
        in_valid  = 1'b0;
        sat_clr   = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        #1;
        chk("rel_in_ready", BW'(in_ready), BW'(1));

        // Plain add
        send1(1000, -100, 1'b0);
        chk("add_valid", BW'(out_valid), BW'(1));
        chk("add_data", out_data, bus2(676, 12024));
        chk("add_sat", BW'(sat_flag), '0);

        // Exact extremes, no clipping
        send1(-130748, 118947, 1'b0);
        chk("edge_data", out_data, bus2(relu(-131072), 131071));
        chk("edge_sat", BW'(sat_flag), '0);

        // Both directions clip
        send1(-131072, 131000, 1'b0);
        chk("sat_data", out_data, bus2(relu(-131072), 131071));
        chk("sat_flag_set", BW'(sat_flag), BW'(1));
        @(negedge clk);
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        #1;
        chk("sat_clr", BW'(sat_flag), '0);

        // New clip on the same cycle as clear wins
        send1(-131072, 0, 1'b1);
        chk("sat_prec", BW'(sat_flag), BW'(1));
        @(negedge clk);
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        #1;
        chk("sat_clr2", BW'(sat_flag), '0);

        // Negative result: ReLU or pass-through
        send1(100, 0, 1'b0);
        chk("relu_data", out_data, bus2(relu(-224), 12124));

        // Backpressure: out_ready low for 5 cycles mid-stream
        sent = 0; rcv = 0; cyc = 0; saw_block = 0; have_prev = 0; prev = '0;
        while (rcv < 6 && cyc < 40) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc < 8);
            in_valid  = (sent < 6);
            in_data   = bus2(2000 + sent, 0);
            #1;
            if (out_valid && !out_ready) begin
                if (have_prev) chk("bp_hold", out_data, prev);
                prev      = out_data;
                have_prev = 1'b1;
            end else begin
                have_prev = 1'b0;
            end
            if (out_valid && out_ready) begin
                chk("bp_order", BW'(out_data[W-1:0]), BW'(1676 + rcv));
                rcv++;
            end
            if (!out_ready && !in_ready) saw_block = 1'b1;
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", BW'(rcv), BW'(6));
        chk("bp_sent", BW'(sent), BW'(6));
        chk("bp_block", BW'(saw_block), BW'(1));

        // Two full frames from a clean counter
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        stream(98, 98, 49, 98);

        // Reset after beat 20 with the pipeline still holding data
        stream(22, 20, -1, -1);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mid_rst_valid", BW'(out_valid), '0);
        chk("mid_rst_last", BW'(out_last), '0);
        @(negedge clk);
        rst_n = 1'b1;
        stream(49, 49, 49, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
